ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave end of the AHB interface) backed by an internal byte-addressable memory array.
- Used as a behavioural or synthesisable memory target for bus masters in the M3 DesignStart testbench and subsystem.
- Supports programmable wait states, byte, halfword and word accesses, and a two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_W, 12: byte-address bits decoded; memory is 2^ADDR_W bytes (word array of 2^(ADDR_W-2) entries); HADDR[31:ADDR_W] ignored.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  bus clock; all state updates on its rising edge.
- hresetn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  in  3  accepted, not used.
- HPROT  in  4  used only with the optional feature.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYMUX  in  1  bus-level HREADY; qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset, asynchronous on hresetn low: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Address phase accepted on a rising edge when HSEL & HREADYMUX & HTRANS[1]. Registered on acceptance: address, write, size, prot.
- HTRANS IDLE or BUSY, or HSEL=0: no transfer; the next cycle gives a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- A transfer is illegal when HSIZE>2, when HSIZE=1 and HADDR[0]=1, or when HSIZE=2 and HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, legal transfer accepted: WAIT_STATES=0 means the data phase completes next cycle with HREADYOUT=1. Otherwise go to WAIT with counter=WAIT_STATES and HREADYOUT=0.
  - WAIT: counter decrements each cycle. When it reaches 0, HREADYOUT=1 and the data phase completes.
  - IDLE, illegal transfer accepted: go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. No memory access occurs.
  - A new address phase may be accepted in the same cycle a data phase completes (back-to-back pipelining). The FSM re-evaluates directly into WAIT, ERR1 or a zero-wait completion.
  - Address phases presented while HREADYOUT=0 are not accepted, because HREADYMUX is low.
- Write:
  - Byte lanes are selected from the registered size and address[1:0]: byte lane = addr[1:0]; halfword lanes = addr[1]?{3,2}:{1,0}; word = all four.
  - HWDATA lanes are committed to the word at addr[ADDR_W-1:2] on the edge ending the data phase (the HREADYOUT=1 cycle). Unselected lanes are unchanged.
- Read:
  - During the read data phase, HRDATA = full memory word at the registered word index, with all lanes driven regardless of size.
  - A read whose address phase overlaps a preceding write's completing data phase returns the newly written data, with no stale read.
  - HRDATA=0 outside read data phases.
- Address wrap: the offset is HADDR[ADDR_W-1:0]. Addresses alias modulo 2^ADDR_W.
- Reset mid-transfer aborts the data phase. No write commits unless its completing edge precedes reset assertion.

Optional Feature:
- Macro: AHB_SRAM_PRIV_CHECK_EN.
- Defined: a transfer with HPROT[1]=0 (user access) whose offset lies in the upper half of memory (HADDR[ADDR_W-1]=1) is treated as illegal. It receives the two-cycle ERROR response and has no memory effect.
- Undefined: HPROT is ignored entirely.

Test Plan:
- Reset then idle (hresetn low 3 cycles, HTRANS=IDLE) -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- WAIT_STATES=0: word write 0xDEADBEEF @0x010, then back-to-back word read @0x010 -> read data phase HRDATA=0xDEADBEEF, HREADYOUT never low.
- WAIT_STATES=2: byte write 0xAA @0x023 over word 0x11223344 @0x020, then word read -> HREADYOUT low exactly 2 cycles per transfer; HRDATA=0xAA223344.
- Halfword write @0x031 (misaligned) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); subsequent read @0x030 unchanged.
- ADDR_W=12: word write 0x5A5A5A5A @0x1004, then read @0x004 -> 0x5A5A5A5A (alias).
- With AHB_SRAM_PRIV_CHECK_EN: user (HPROT=0000) write @0x800 -> ERROR, memory unchanged. Privileged (HPROT=0010) write @0x800 -> OKAY. Without the macro, both OKAY.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a word-organised, byte-writable memory.
// Optional feature macro: AHB_SRAM_PRIV_CHECK_EN (user accesses to the upper half are rejected).
module ahb_sram_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADYMUX,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                dp_valid, dp_valid_nxt;
  logic                dp_write;
  logic [1:0]          dp_size;
  logic [ADDR_W-1:0]   dp_addr;
  logic                accept;
  logic                illegal;
  logic                wr_en;
  logic [3:0]          lane_en;
  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         mem [WORDS];

  // Bus-level signals this responder does not act on.
  logic unused_ok;
  assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HADDR[31:ADDR_W]};

  assign accept   = HSEL & HREADYMUX & HTRANS[1];
  assign word_idx = dp_addr[ADDR_W-1:2];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    illegal = 1'b0;
    case (HSIZE)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = HADDR[0];
      3'b010:  illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
`ifdef AHB_SRAM_PRIV_CHECK_EN
    if (!HPROT[1] && HADDR[ADDR_W-1]) illegal = 1'b1;
`endif
  end

  assign HREADYOUT = !((state == S_ERR1) || ((state == S_WAIT) && (cnt != 4'd0)));
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

  // Whenever HREADYOUT is high the current data phase ends, so a new address phase is evaluated.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dp_valid_nxt = dp_valid;
    if (HREADYOUT) begin
      state_nxt    = S_IDLE;
      cnt_nxt      = 4'd0;
      dp_valid_nxt = 1'b0;
      if (accept) begin
        if (illegal) begin
          state_nxt = S_ERR1;
        end else begin
          dp_valid_nxt = 1'b1;
          if (WAIT_STATES != 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
    end else if (state == S_ERR1) begin
      state_nxt = S_ERR2;
    end else begin
      cnt_nxt = cnt - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 2'b00;
      dp_addr  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dp_valid <= dp_valid_nxt;
      if (HREADYOUT && accept) begin
        dp_write <= HWRITE;
        dp_size  <= HSIZE[1:0];
        dp_addr  <= HADDR[ADDR_W-1:0];
      end
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (dp_size)
      2'b00:   lane_en[dp_addr[1:0]] = 1'b1;
      2'b01:   lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Only legal transfers set dp_valid, and reset clears it, so an aborted phase never commits.
  assign wr_en = dp_valid & dp_write & HREADYOUT;

  // NOTE: the memory array has no reset; its contents are undefined until written.
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Asynchronous read sees a write committed on the edge that started this read phase.
  assign HRDATA = (dp_valid && !dp_write) ? mem[word_idx] : 32'h0;

endmodule
